// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem address and IF/ID register.
// Handles boot bubble, decode stalls, redirect flushes, bubble count.
module fetch_stage #(
    parameter int unsigned      ISIZE    = 16,
    parameter logic [ISIZE-1:0] RESET_PC = '0,
    parameter logic [ISIZE-1:0] NOP_INST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    output logic [ISIZE-1:0] pc_out,
    output logic [ISIZE-1:0] inst_out,
    output logic [ISIZE-1:0] npc_out,
    output logic             valid_out,
    output logic             stalled,
    output logic [15:0]      bubbles
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [ISIZE-1:0] ONE = {{(ISIZE-1){1'b0}}, 1'b1};

    state_t           state;
    logic [ISIZE-1:0] pc;
    logic [ISIZE-1:0] pc_inc;
    logic [15:0]      bub_inc;

    assign pc_inc    = pc + ONE;
    assign bub_inc   = (bubbles == 16'hFFFF) ? bubbles : bubbles + 16'd1;
    assign imem_addr = pc;
    assign pc_out    = pc;

    // Fetch FSM: boot bubble, then redirect > stall > advance each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            inst_out  <= NOP_INST;
            npc_out   <= '0;
            valid_out <= 1'b0;
            stalled   <= 1'b0;
            bubbles   <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    bubbles <= bub_inc;
                    state   <= RUN;
                    stalled <= 1'b0;
                end
                default: begin
                    if (redirect) begin
                        pc        <= redirect_pc;
                        inst_out  <= NOP_INST;
                        npc_out   <= '0;
                        valid_out <= 1'b0;
                        bubbles   <= bub_inc;
                        state     <= RUN;
                        stalled   <= 1'b0;
                    end else if (stall) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                    end else begin
                        pc        <= pc_inc;
                        inst_out  <= imem_data;
                        npc_out   <= pc_inc;
                        valid_out <= 1'b1;
                        state     <= RUN;
                        stalled   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Directed scenarios plus random stall/redirect traffic vs a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc_out;
    logic [15:0] inst_out;
    logic [15:0] npc_out;
    logic        valid_out;
    logic        stalled;
    logic [15:0] bubbles;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [15:0] m_pc, m_inst, m_npc, m_bub;
    logic        m_valid, m_stalled, m_boot;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out),
        .stalled     (stalled),
        .bubbles     (bubbles)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        logic [15:0] r;
        r = a + 16'h1000;
        return r;
    endfunction

    assign imem_data = mem(imem_addr);

    function automatic logic [65:0] dut_vec();
        return {pc_out, inst_out, npc_out, valid_out, stalled, bubbles};
    endfunction

    function automatic logic [65:0] mdl_vec();
        return {m_pc, m_inst, m_npc, m_valid, m_stalled, m_bub};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_npc = 16'h0000;
        m_valid = 1'b0; m_stalled = 1'b0; m_bub = 16'h0000;
        m_boot = 1'b1;
    endtask

    // one clock: update the model from the current inputs, then sample
    task automatic cycle();
        logic [15:0] nxt;
        if (m_boot) begin
            m_boot = 1'b0;
            if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        end else if (redirect) begin
            m_pc = redirect_pc; m_inst = 16'h0000; m_npc = 16'h0000;
            m_valid = 1'b0; m_stalled = 1'b0;
            if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        end else if (stall) begin
            m_stalled = 1'b1;
        end else begin
            nxt = m_pc + 16'd1;
            m_inst = mem(m_pc); m_npc = nxt; m_pc = nxt;
            m_valid = 1'b1; m_stalled = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (dut_vec() !== mdl_vec() || imem_addr !== 16'h0000)
            $display("FAIL reset: got %h addr %h want %h", dut_vec(), imem_addr, mdl_vec());
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_boot_advance();
        cycle();
        n_total++;
        if (valid_out !== 1'b0 || bubbles !== 16'd1 || pc_out !== 16'd0)
            $display("FAIL boot: valid %b bub %h pc %h want 0 0001 0000", valid_out, bubbles, pc_out);
        else n_pass++;
        cycle();
        n_total++;
        if (inst_out !== 16'h1000 || npc_out !== 16'd1 || valid_out !== 1'b1)
            $display("FAIL first_inst: inst %h npc %h v %b want 1000 0001 1", inst_out, npc_out, valid_out);
        else n_pass++;
        cycle();
        n_total++;
        if (inst_out !== 16'h1001 || npc_out !== 16'd2 || dut_vec() !== mdl_vec())
            $display("FAIL second_inst: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
    endtask

    task automatic test_stall();
        while (m_pc != 16'd5) cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++;
            if (dut_vec() !== mdl_vec() || pc_out !== 16'd5 || stalled !== 1'b1)
                $display("FAIL stall_%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else n_pass++;
        end
        stall = 1'b0;
        cycle();
        n_total++;
        if (inst_out !== mem(16'd5) || pc_out !== 16'd6 || stalled !== 1'b0)
            $display("FAIL stall_release: inst %h pc %h st %b want %h 0006 0", inst_out, pc_out, stalled, mem(16'd5));
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [15:0] b0;
        b0 = bubbles;
        redirect = 1'b1; redirect_pc = 16'h0040;
        cycle();
        redirect = 1'b0;
        n_total++;
        if (pc_out !== 16'h0040 || inst_out !== 16'h0000 || valid_out !== 1'b0 || bubbles !== b0 + 16'd1)
            $display("FAIL redirect: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
        cycle();
        n_total++;
        if (inst_out !== mem(16'h0040) || npc_out !== 16'h0041 || dut_vec() !== mdl_vec())
            $display("FAIL redirect_fetch: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        cycle();
        redirect = 1'b1; redirect_pc = 16'h0020;
        cycle();
        stall = 1'b0; redirect = 1'b0;
        n_total++;
        if (pc_out !== 16'h0020 || valid_out !== 1'b0 || stalled !== 1'b0 || dut_vec() !== mdl_vec())
            $display("FAIL stall_redirect: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        cycle();
        redirect = 1'b0;
        cycle();
        n_total++;
        if (inst_out !== mem(16'hFFFF) || npc_out !== 16'h0000 || pc_out !== 16'h0000)
            $display("FAIL wrap: inst %h npc %h pc %h want %h 0000 0000", inst_out, npc_out, pc_out, mem(16'hFFFF));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 9) < 2);
            redirect_pc = 16'($urandom);
            cycle();
            n_total++;
            if (dut_vec() !== mdl_vec() || imem_addr !== m_pc)
                $display("FAIL random_%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else n_pass++;
        end
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #4;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        redirect = 1'b1;
        for (int i = 0; i < 6; i++) begin
            redirect_pc = 16'($urandom);
            cycle();
        end
        redirect = 1'b0; stall = 1'b1;
        cycle();
        cycle();
        n_total++;
        if (bubbles !== 16'd7 || stalled !== 1'b1)
            $display("FAIL pre_async: bub %h st %b want 0007 1", bubbles, stalled);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (pc_out !== 16'h0000 || valid_out !== 1'b0 || stalled !== 1'b0 || bubbles !== 16'd0)
            $display("FAIL async_reset: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        cycle();
        redirect = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            redirect_pc = 16'(i);
            cycle();
        end
        redirect = 1'b0;
        n_total++;
        if (bubbles !== 16'hFFFF || dut_vec() !== mdl_vec())
            $display("FAIL saturate: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
        cycle();
        n_total++;
        if (bubbles !== 16'hFFFF || valid_out !== 1'b1 || dut_vec() !== mdl_vec())
            $display("FAIL saturate_hold: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_boot_advance();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
